// File: rtl/tmul_pkg.sv
// Shared constants and row/column types for the tile multiplier
// datapath and its result drain.
package tmul_pkg;

  localparam int TMUL_N       = 8;
  localparam int TMUL_W       = 64;
  localparam int TMUL_LATENCY = 8;

  typedef logic [TMUL_W-1:0] tmul_col_t;
  typedef tmul_col_t [TMUL_N-1:0] tmul_row_t;

endpackage

// File: rtl/tmul_row_fifo.sv
// Row buffer between multiplier capture and the column serializer.
// Head is read combinationally; push and pop may coincide at any fill.
module tmul_row_fifo
  import tmul_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = tmul_row_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  T                           wdata,
  output T                           head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  T                mem_q [DEPTH];
  logic [AW-1:0]   wr_q;
  logic [AW-1:0]   rd_q;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;
  logic            rd_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNTW'(DEPTH));
  assign rd_en = pop & ~empty;
  assign head  = mem_q[rd_q];
  assign cnt   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, rd_en})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= wr_q + AW'(1);
      end
      if (rd_en) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tmul_result_drain.sv
// Captures multiplier result rows, buffers them and streams them out
// one column per beat; issue credits keep the row buffer from overflowing.
module tmul_result_drain
  import tmul_pkg::*;
#(
  parameter int N       = TMUL_N,
  parameter int W       = TMUL_W,
  parameter int LATENCY = TMUL_LATENCY,
  parameter int DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [N-1:0][W-1:0]   c_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data,
  output logic [$clog2(N)-1:0]  out_col,
  output logic                  out_last
);

  localparam int CW  = $clog2(N);
  localparam int CRW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] LAST_COL = CW'(N-1);

  typedef logic [N-1:0][W-1:0] row_t;
  typedef enum logic {S_IDLE, S_SEND} state_e;

  state_e             st_q, st_d;
  logic [CW-1:0]      col_q, col_d;
  logic [CRW-1:0]     cred_q, cred_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic               issue_hs;
  logic               beat_hs;
  logic               last_hs;
  logic               push;
  logic               fifo_empty;
  logic               fifo_full;
  logic [CRW-1:0]     fifo_cnt;
  row_t               head;

  assign issue_ready = (cred_q < CRW'(DEPTH));
  assign issue_hs    = issue_valid & issue_ready;
  assign beat_hs     = (st_q == S_SEND) & out_ready;
  assign last_hs     = beat_hs & (col_q == LAST_COL);
  // Credits already bound occupancy; the full check is a safety net.
  assign push        = vld_q[LATENCY-1] & (~fifo_full | last_hs);
  assign vld_d       = LATENCY'({vld_q, issue_hs});

  tmul_row_fifo #(
    .DEPTH (DEPTH),
    .T     (row_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (last_hs),
    .wdata (c_in),
    .head  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .cnt   (fifo_cnt)
  );

  always_comb begin
    cred_d = cred_q;
    unique case ({issue_hs, last_hs})
      2'b10:   cred_d = cred_q + CRW'(1);
      2'b01:   cred_d = cred_q - CRW'(1);
      default: ;
    endcase
  end

  // Looking at push lets a row leave the cycle after capture.
  always_comb begin
    st_d      = st_q;
    col_d     = col_q;
    out_valid = 1'b0;
    out_data  = '0;
    out_col   = '0;
    out_last  = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        col_d = '0;
        if (!fifo_empty || push) begin
          st_d = S_SEND;
        end
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_data  = head[col_q];
        out_col   = col_q;
        out_last  = (col_q == LAST_COL);
        if (beat_hs) begin
          if (col_q != LAST_COL) begin
            col_d = col_q + CW'(1);
          end else begin
            col_d = '0;
            if (fifo_cnt == CRW'(1) && !push) begin
              st_d = S_IDLE;
            end
          end
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= S_IDLE;
      col_q  <= '0;
      cred_q <= '0;
      vld_q  <= '0;
    end else begin
      st_q   <= st_d;
      col_q  <= col_d;
      cred_q <= cred_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: tb/tb_tmul_result_drain.sv
// Directed bench for tmul_result_drain: reset, streaming, credits,
// stall stability, coincident capture/pop and mid-stream reset.
module tb_tmul_result_drain;
  import tmul_pkg::*;

  localparam int N   = TMUL_N;
  localparam int W   = TMUL_W;
  localparam int LAT = TMUL_LATENCY;
  localparam int DEP = 4;
  localparam int CW  = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic          issue_ready;
  tmul_row_t     c_in;
  tmul_row_t     tb_row_in;
  tmul_row_t     pipe [LAT];
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_col;
  logic          out_last;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tmul_result_drain #(
    .N       (N),
    .W       (W),
    .LATENCY (LAT),
    .DEPTH   (DEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .c_in        (c_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_col     (out_col),
    .out_last    (out_last)
  );

  // Stand-in for the multiplier: the row offered with an issue
  // appears on c_in LAT cycles later.
  always @(posedge clk) begin
    pipe[0] <= tb_row_in;
    for (int i = 1; i < LAT; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end
  assign c_in = pipe[LAT-1];

  function automatic logic [W-1:0] mkcol(int r, int j);
    return W'((r << 8) | (j + 1));
  endfunction

  function automatic tmul_row_t mkrow(int r);
    tmul_row_t v;
    for (int j = 0; j < N; j++) v[j] = mkcol(r, j);
    return v;
  endfunction

  function automatic tmul_row_t poison();
    tmul_row_t v;
    for (int j = 0; j < N; j++) v[j] = 64'hDEAD_0000_0000_0000 | W'(j);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    issue_valid = 1'b0;
    out_ready   = 1'b0;
    tb_row_in   = poison();
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({issue_ready, out_valid, out_data, out_col, out_last}
        !== {1'b1, 1'b0, 64'd0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b v=%b d=%h c=%0d l=%b want 1 0 0 0 0",
               issue_ready, out_valid, out_data, out_col, out_last);
    end
    tick();
    checks++;
    if ({issue_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL reset_idle got rdy=%b v=%b want 1 0", issue_ready, out_valid);
    end
  endtask

  task automatic test_single();
    logic [CW-1:0] ec;
    out_ready   = 1'b1;
    issue_valid = 1'b1;
    tb_row_in   = mkrow(0);
    tick();
    issue_valid = 1'b0;
    tb_row_in   = poison();
    for (int c = 1; c <= 18; c++) begin
      if (c >= 9 && c <= 16) begin
        ec = CW'(c - 9);
        checks++;
        if ({out_valid, out_data, out_col, out_last}
            !== {1'b1, W'(c - 8), ec, (c == 16)}) begin
          failures++;
          $display("FAIL single_beat cyc=%0d got v=%b d=%h c=%0d l=%b want v=1 d=%h c=%0d l=%b",
                   c, out_valid, out_data, out_col, out_last, W'(c - 8), ec, (c == 16));
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL single_idle cyc=%0d got v=%b want 0", c, out_valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int beats;
    int c;
    int extra;
    logic [CW-1:0] ec;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        checks++;
        if (issue_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_ready_low got %b want 0", issue_ready);
        end
      end
      issue_valid = 1'b1;
      tb_row_in   = (i < 4) ? mkrow(1 + i) : poison();
      tick();
    end
    issue_valid = 1'b0;
    tb_row_in   = poison();
    repeat (9) tick();
    checks++;
    if ({issue_ready, out_valid, out_data, out_col}
        !== {1'b0, 1'b1, mkcol(1, 0), 3'd0}) begin
      failures++;
      $display("FAIL bp_stalled_head got rdy=%b v=%b d=%h c=%0d want 0 1 %h 0",
               issue_ready, out_valid, out_data, out_col, mkcol(1, 0));
    end
    out_ready = 1'b1;
    beats = 0;
    for (c = 0; c < 60 && beats < 32; c++) begin
      if (c == 7 || c == 8) begin
        checks++;
        if (issue_ready !== (c == 8)) begin
          failures++;
          $display("FAIL bp_credit_return rel=%0d got %b want %b",
                   c, issue_ready, (c == 8));
        end
      end
      if (out_valid) begin
        ec = CW'(beats % 8);
        checks++;
        if ({out_data, out_col, out_last}
            !== {mkcol(1 + beats / 8, beats % 8), ec, (beats % 8 == 7)}) begin
          failures++;
          $display("FAIL bp_beat n=%0d got d=%h c=%0d l=%b want d=%h c=%0d",
                   beats, out_data, out_col, out_last,
                   mkcol(1 + beats / 8, beats % 8), ec);
        end
        beats++;
      end
      tick();
    end
    checks++;
    if (beats != 32 || c != 32) begin
      failures++;
      $display("FAIL bp_count got beats=%0d cycles=%0d want 32 32", beats, c);
    end
    checks++;
    if ({out_valid, issue_ready} !== 2'b01) begin
      failures++;
      $display("FAIL bp_drained got v=%b rdy=%b want 0 1", out_valid, issue_ready);
    end
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) extra++;
      tick();
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL bp_no_extra got %0d extra beats want 0", extra);
    end
  endtask

  task automatic test_stall();
    logic [31:0]   pat;
    logic          prev_stall;
    logic [W-1:0]  pd;
    logic [CW-1:0] pc;
    logic          pl;
    logic [CW-1:0] ec;
    int            beats;
    pat        = 32'b1101_0011_1000_1011_0110_0101_1110_0010;
    prev_stall = 1'b0;
    pd         = '0;
    pc         = '0;
    pl         = 1'b0;
    beats      = 0;
    for (int c = 0; c < 150 && beats < 16; c++) begin
      issue_valid = (c < 2);
      tb_row_in   = (c == 0) ? mkrow(5) : (c == 1) ? mkrow(6) : poison();
      out_ready   = pat[c % 32];
      if (prev_stall) begin
        checks++;
        if ({out_valid, out_data, out_col, out_last} !== {1'b1, pd, pc, pl}) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got v=%b d=%h c=%0d l=%b want 1 %h %0d %b",
                   c, out_valid, out_data, out_col, out_last, pd, pc, pl);
        end
      end
      if (out_valid && out_ready) begin
        ec = CW'(beats % 8);
        checks++;
        if ({out_data, out_col, out_last}
            !== {mkcol(5 + beats / 8, beats % 8), ec, (beats % 8 == 7)}) begin
          failures++;
          $display("FAIL stall_beat n=%0d got d=%h c=%0d l=%b want d=%h c=%0d",
                   beats, out_data, out_col, out_last,
                   mkcol(5 + beats / 8, beats % 8), ec);
        end
        beats++;
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data;
      pc = out_col;
      pl = out_last;
      tick();
    end
    issue_valid = 1'b0;
    out_ready   = 1'b1;
    checks++;
    if (beats != 16) begin
      failures++;
      $display("FAIL stall_count got %0d want 16", beats);
    end
    repeat (4) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_tail got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_full_simul();
    int beats;
    logic [CW-1:0] ec;
    out_ready = 1'b0;
    beats = 0;
    for (int c = 0; c < 80 && beats < 32; c++) begin
      issue_valid = (c <= 2) || (c == 10);
      tb_row_in   = (c <= 2)  ? mkrow(10 + c) :
                    (c == 10) ? mkrow(13) : poison();
      out_ready   = (c >= 11);
      if (c == 9) begin
        checks++;
        if ({out_valid, out_data} !== {1'b1, mkcol(10, 0)}) begin
          failures++;
          $display("FAIL full_head got v=%b d=%h want 1 %h",
                   out_valid, out_data, mkcol(10, 0));
        end
      end
      if (c == 10 || c == 18 || c == 19) begin
        checks++;
        if (issue_ready !== (c != 18)) begin
          failures++;
          $display("FAIL full_credit cyc=%0d got %b want %b",
                   c, issue_ready, (c != 18));
        end
      end
      if (out_valid && out_ready) begin
        ec = CW'(beats % 8);
        checks++;
        if ({out_data, out_col, out_last}
            !== {mkcol(10 + beats / 8, beats % 8), ec, (beats % 8 == 7)}) begin
          failures++;
          $display("FAIL full_beat n=%0d got d=%h c=%0d l=%b want d=%h c=%0d",
                   beats, out_data, out_col, out_last,
                   mkcol(10 + beats / 8, beats % 8), ec);
        end
        beats++;
      end
      tick();
    end
    issue_valid = 1'b0;
    tb_row_in   = poison();
    checks++;
    if (beats != 32) begin
      failures++;
      $display("FAIL full_count got %0d want 32", beats);
    end
    repeat (3) tick();
    checks++;
    if ({out_valid, issue_ready} !== 2'b01) begin
      failures++;
      $display("FAIL full_drained got v=%b rdy=%b want 0 1", out_valid, issue_ready);
    end
  endtask

  task automatic test_reset_mid();
    int stale;
    int beats;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      issue_valid = (c <= 2);
      tb_row_in   = (c <= 2) ? mkrow(20 + c) : poison();
      tick();
    end
    issue_valid = 1'b0;
    tb_row_in   = poison();
    checks++;
    if ({out_valid, out_data, out_col} !== {1'b1, mkcol(21, 3), 3'd3}) begin
      failures++;
      $display("FAIL rm_pre got v=%b d=%h c=%0d want 1 %h 3",
               out_valid, out_data, out_col, mkcol(21, 3));
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({issue_ready, out_valid, out_data, out_col, out_last}
        !== {1'b1, 1'b0, 64'd0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL rm_async got rdy=%b v=%b d=%h c=%0d l=%b want 1 0 0 0 0",
               issue_ready, out_valid, out_data, out_col, out_last);
    end
    tick();
    tick();
    rst = 1'b1;
    stale = 0;
    for (int k = 0; k < 30; k++) begin
      if (out_valid) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin
      failures++;
      $display("FAIL rm_no_stale got %0d valid cycles want 0", stale);
    end
    issue_valid = 1'b1;
    tb_row_in   = mkrow(30);
    tick();
    issue_valid = 1'b0;
    tb_row_in   = poison();
    beats = 0;
    for (int c = 1; c <= 20; c++) begin
      if (out_valid) begin
        checks++;
        if ({out_data, c >= 9 && c <= 16} !== {mkcol(30, beats), 1'b1}) begin
          failures++;
          $display("FAIL rm_recover cyc=%0d got d=%h want %h in cycles 9-16",
                   c, out_data, mkcol(30, beats));
        end
        beats++;
      end
      tick();
    end
    checks++;
    if (beats != 8) begin
      failures++;
      $display("FAIL rm_recover_count got %0d want 8", beats);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_stall();
    test_full_simul();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
